// File: rtl/player_link_negotiator.sv
// Role handshake between two boards over UART byte streams: the main board says hello,
// the side board answers, and the main board acknowledges, with timeouts and a bounded retry count.
module player_link_negotiator #(
   parameter int TIMEOUT_CYCLES = 65_000_000,
   parameter int MAX_RETRIES    = 8,
   localparam int W             = $clog2(MAX_RETRIES + 1)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [1:0]   selected_player,
   output logic [7:0]   tx_data,
   output logic         tx_valid,
   input  logic         tx_ready,
   input  logic [7:0]   rx_data,
   input  logic         rx_valid,
   output logic         linked,
   output logic         conflict,
   output logic         link_fail,
   output logic [W-1:0] retry_cnt
);

   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [W-1:0]  RETRY_MAX  = W'(MAX_RETRIES);

   localparam logic [7:0] HELLO_MAIN = 8'hA1;
   localparam logic [7:0] HELLO_SIDE = 8'hA3;
   localparam logic [7:0] ACK        = 8'h5A;

   typedef enum logic [3:0] {
      IDLE,
      M_SEND,
      M_WAIT,
      M_ACK,
      S_WAIT,
      S_SEND,
      S_ACKW,
      LINKED,
      CONFLICT,
      FAIL
   } state_t;

   state_t        state, state_next;
   logic [TW-1:0] timer, timer_next;
   logic [W-1:0]  retry_next, retry_inc;
   logic [7:0]    tx_data_next;
   logic          accept, timeout, retry_left;
   logic          rx_main, rx_side, rx_ack;

   assign accept     = tx_valid && tx_ready;
   assign timeout    = (timer == TIMER_LAST);
   assign retry_left = (retry_cnt < RETRY_MAX);
   assign retry_inc  = retry_left ? retry_cnt + 1'b1 : retry_cnt;
   assign rx_main    = rx_valid && (rx_data == HELLO_MAIN);
   assign rx_side    = rx_valid && (rx_data == HELLO_SIDE);
   assign rx_ack     = rx_valid && (rx_data == ACK);

   always_comb begin
      state_next = state;
      timer_next = timer;
      retry_next = retry_cnt;
      unique case (state)
         IDLE: begin
            if (selected_player == 2'b01)
               state_next = M_SEND;
            else if (selected_player == 2'b11)
               state_next = S_WAIT;
         end
         M_SEND: begin
            if (rx_main)
               state_next = CONFLICT;
            else if (accept) begin
               timer_next = '0;
               retry_next = retry_inc;
               state_next = rx_side ? M_ACK : M_WAIT;
            end
         end
         M_WAIT: begin
            if (rx_main)
               state_next = CONFLICT;
            else if (rx_side)
               state_next = M_ACK;
            else if (timeout)
               state_next = retry_left ? M_SEND : FAIL;
            else
               timer_next = timer + 1'b1;
         end
         M_ACK: begin
            if (rx_main)
               state_next = CONFLICT;
            else if (accept)
               state_next = LINKED;
         end
         S_WAIT: begin
            if (rx_side)
               state_next = CONFLICT;
            else if (rx_main)
               state_next = S_SEND;
         end
         S_SEND: begin
            if (rx_side)
               state_next = CONFLICT;
            else if (accept) begin
               timer_next = '0;
               retry_next = retry_inc;
               state_next = rx_ack ? LINKED : S_ACKW;
            end
         end
         S_ACKW: begin
            // A repeated hello means the main board missed our reply, so answer again.
            if (rx_side)
               state_next = CONFLICT;
            else if (rx_ack)
               state_next = LINKED;
            else if (rx_main)
               state_next = S_SEND;
            else if (timeout)
               state_next = retry_left ? S_WAIT : FAIL;
            else
               timer_next = timer + 1'b1;
         end
         default: state_next = state;
      endcase
   end

   always_comb begin
      tx_data_next = tx_data;
      case (state_next)
         M_SEND:  tx_data_next = HELLO_MAIN;
         M_ACK:   tx_data_next = ACK;
         S_SEND:  tx_data_next = HELLO_SIDE;
         default: tx_data_next = tx_data;
      endcase
   end

   // Outputs are registered from the next state so they line up with the state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         timer     <= '0;
         retry_cnt <= '0;
         tx_data   <= 8'h00;
         tx_valid  <= 1'b0;
         linked    <= 1'b0;
         conflict  <= 1'b0;
         link_fail <= 1'b0;
      end else begin
         state     <= state_next;
         timer     <= timer_next;
         retry_cnt <= retry_next;
         tx_data   <= tx_data_next;
         tx_valid  <= (state_next == M_SEND) || (state_next == M_ACK) || (state_next == S_SEND);
         linked    <= (state_next == LINKED);
         conflict  <= (state_next == CONFLICT);
         link_fail <= (state_next == FAIL);
      end
   end

endmodule

// File: tb/tb_player_link_negotiator.sv
// Bench for player_link_negotiator: a protocol-level model checked every cycle,
// directed scenarios with literal expectations, then randomized episodes.
module tb_player_link_negotiator;

   localparam int T = 16;
   localparam int M = 3;
   localparam int W = $clog2(M + 1);
   localparam logic [7:0] HM  = 8'hA1;
   localparam logic [7:0] HS  = 8'hA3;
   localparam logic [7:0] ACK = 8'h5A;

   logic         clk = 1'b0;
   logic         rst;
   logic [1:0]   selected_player;
   logic [7:0]   tx_data;
   logic         tx_valid;
   logic         tx_ready;
   logic [7:0]   rx_data;
   logic         rx_valid;
   logic         linked;
   logic         conflict;
   logic         link_fail;
   logic [W-1:0] retry_cnt;

   int n_checks = 0;
   int n_fail   = 0;
   logic [7:0] acc_q[$];

   always #5 clk = ~clk;

   player_link_negotiator #(.TIMEOUT_CYCLES(T), .MAX_RETRIES(M)) dut (
      .clk(clk),
      .rst(rst),
      .selected_player(selected_player),
      .tx_data(tx_data),
      .tx_valid(tx_valid),
      .tx_ready(tx_ready),
      .rx_data(rx_data),
      .rx_valid(rx_valid),
      .linked(linked),
      .conflict(conflict),
      .link_fail(link_fail),
      .retry_cnt(retry_cnt)
   );

   // Protocol model: outcome 0 running, 1 linked, 2 conflict, 3 failed; role 0 none, 1 main, 2 side.
   int         m_outcome, m_role, m_attempts, m_elapsed;
   bit         m_offering, m_awaiting;
   logic [7:0] m_byte;

   task automatic model_reset();
      m_outcome  = 0;
      m_role     = 0;
      m_attempts = 0;
      m_elapsed  = 0;
      m_offering = 0;
      m_awaiting = 0;
      m_byte     = 8'h00;
   endtask

   task automatic model_offer(input logic [7:0] b);
      m_offering = 1;
      m_byte     = b;
   endtask

   task automatic model_reply();
      m_awaiting = 0;
      if (m_role == 1) model_offer(ACK);
      else m_outcome = 1;
   endtask

   task automatic model_step();
      logic [7:0] own, reply;
      bit rx_own, rx_reply, rx_hm;
      if (rst) begin
         model_reset();
         return;
      end
      if (m_outcome != 0) return;
      if (m_role == 0) begin
         if (selected_player == 2'b01) begin
            m_role = 1;
            model_offer(HM);
         end else if (selected_player == 2'b11) begin
            m_role = 2;
         end
         return;
      end
      own      = (m_role == 1) ? HM : HS;
      reply    = (m_role == 1) ? HS : ACK;
      rx_own   = rx_valid && (rx_data == own);
      rx_reply = rx_valid && (rx_data == reply);
      rx_hm    = rx_valid && (rx_data == HM);
      if (rx_own) begin
         m_outcome  = 2;
         m_offering = 0;
         m_awaiting = 0;
         return;
      end
      if (m_offering) begin
         if (tx_ready) begin
            m_offering = 0;
            if (m_byte == ACK) m_outcome = 1;
            else begin
               if (m_attempts < M) m_attempts++;
               m_awaiting = 1;
               m_elapsed  = 0;
               if (rx_reply) model_reply();
            end
         end
      end else if (m_awaiting) begin
         if (rx_reply) model_reply();
         else if (m_role == 2 && rx_hm) begin
            m_awaiting = 0;
            model_offer(HS);
         end else if (m_elapsed == T - 1) begin
            m_awaiting = 0;
            if (m_attempts < M) begin
               if (m_role == 1) model_offer(HM);
            end else m_outcome = 3;
         end else m_elapsed++;
      end else if (m_role == 2 && rx_hm) begin
         model_offer(HS);
      end
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Drive one rx strobe (or none) and let n cycles pass; inputs change only at negedges.
   task automatic applyStimulus(input logic rv, input logic [7:0] rd, input int n);
      rx_valid = rv;
      rx_data  = rd;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         rx_valid = 1'b0;
      end
   endtask

   task automatic do_reset();
      rst             = 1'b1;
      selected_player = 2'b00;
      tx_ready        = 1'b1;
      applyStimulus(1'b0, 8'h00, 2);
      rst = 1'b0;
      acc_q.delete();
   endtask

   // Per-cycle comparison against the model, sampled just after each rising edge.
   initial begin
      forever begin
         @(posedge clk);
         if (!rst && tx_valid && tx_ready) acc_q.push_back(tx_data);
         model_step();
         #1;
         checkOutput("tx_valid", tx_valid, m_offering);
         if (m_offering) checkOutput("tx_data", tx_data, m_byte);
         checkOutput("linked", linked, m_outcome == 1);
         checkOutput("conflict", conflict, m_outcome == 2);
         checkOutput("link_fail", link_fail, m_outcome == 3);
         checkOutput("retry_cnt", retry_cnt, m_attempts);
      end
   end

   initial begin
      int rate;
      logic rv;
      logic [7:0] rd;
      rst = 1'b1;
      selected_player = 2'b00;
      tx_ready = 1'b1;
      rx_valid = 1'b0;
      rx_data = 8'h00;
      model_reset();

      do_reset();
      checkOutput("reset tx_data", tx_data, 8'h00);
      checkOutput("reset tx_valid", tx_valid, 0);
      checkOutput("reset retry_cnt", retry_cnt, 0);

      // Main happy path.
      selected_player = 2'b01;
      applyStimulus(1'b0, 8'h00, 4);
      applyStimulus(1'b1, HS, 5);
      checkOutput("main linked", linked, 1);
      checkOutput("main retry_cnt", retry_cnt, 1);
      checkOutput("main tx count", acc_q.size(), 2);
      if (acc_q.size() == 2) begin
         checkOutput("main tx0", acc_q[0], HM);
         checkOutput("main tx1", acc_q[1], ACK);
      end

      // Main timeout with no reply.
      do_reset();
      selected_player = 2'b01;
      applyStimulus(1'b0, 8'h00, 3 * (T + 1) + 20);
      checkOutput("timeout hello count", acc_q.size(), 3);
      foreach (acc_q[i]) checkOutput("timeout hello byte", acc_q[i], HM);
      checkOutput("timeout link_fail", link_fail, 1);
      checkOutput("timeout retry_cnt", retry_cnt, 3);
      checkOutput("timeout tx_valid", tx_valid, 0);

      // Side path, then a late hello must be ignored.
      do_reset();
      selected_player = 2'b11;
      applyStimulus(1'b0, 8'h00, 3);
      checkOutput("side idle tx_valid", tx_valid, 0);
      applyStimulus(1'b1, HM, 4);
      applyStimulus(1'b1, ACK, 3);
      checkOutput("side linked", linked, 1);
      applyStimulus(1'b1, HM, 4);
      checkOutput("side tx count", acc_q.size(), 1);
      if (acc_q.size() == 1) checkOutput("side tx0", acc_q[0], HS);
      checkOutput("side late tx_valid", tx_valid, 0);

      // Backpressure holds the hello stable until accepted once.
      do_reset();
      selected_player = 2'b01;
      tx_ready = 1'b0;
      applyStimulus(1'b0, 8'h00, 12);
      checkOutput("bp tx_valid", tx_valid, 1);
      checkOutput("bp tx_data", tx_data, HM);
      checkOutput("bp no accept", acc_q.size(), 0);
      tx_ready = 1'b1;
      applyStimulus(1'b0, 8'h00, 4);
      checkOutput("bp single accept", acc_q.size(), 1);

      // Conflict while waiting, then while a hello is still unaccepted.
      do_reset();
      selected_player = 2'b01;
      applyStimulus(1'b0, 8'h00, 4);
      applyStimulus(1'b1, HM, 3);
      checkOutput("conflict wait", conflict, 1);
      checkOutput("conflict wait linked", linked, 0);
      do_reset();
      selected_player = 2'b01;
      tx_ready = 1'b0;
      applyStimulus(1'b0, 8'h00, 3);
      checkOutput("conflict send pre", tx_valid, 1);
      applyStimulus(1'b1, HM, 1);
      checkOutput("conflict send tx_valid", tx_valid, 0);
      checkOutput("conflict send flag", conflict, 1);

      // Reset in the middle of the side handshake; a role change beforehand is ignored.
      do_reset();
      selected_player = 2'b11;
      applyStimulus(1'b0, 8'h00, 2);
      applyStimulus(1'b1, HM, 4);
      selected_player = 2'b01;
      applyStimulus(1'b0, 8'h00, 3);
      checkOutput("midop tx_valid", tx_valid, 0);
      checkOutput("midop retry_cnt", retry_cnt, 1);
      rst = 1'b1;
      applyStimulus(1'b0, 8'h00, 1);
      checkOutput("rst tx_valid", tx_valid, 0);
      checkOutput("rst tx_data", tx_data, 8'h00);
      checkOutput("rst retry_cnt", retry_cnt, 0);
      checkOutput("rst flags", {linked, conflict, link_fail}, 3'b000);
      rst = 1'b0;
      applyStimulus(1'b0, 8'h00, 3);

      // Randomized episodes.
      for (int ep = 0; ep < 60; ep++) begin
         do_reset();
         selected_player = 2'($urandom_range(0, 3));
         rate = $urandom_range(3, 30);
         for (int c = 0; c < 150; c++) begin
            tx_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 39) == 0) selected_player = 2'($urandom_range(0, 3));
            rst = ($urandom_range(0, 199) == 0);
            rv = ($urandom_range(0, rate - 1) == 0);
            case ($urandom_range(0, 4))
               0: rd = HM;
               1: rd = HS;
               2: rd = ACK;
               default: rd = 8'($urandom_range(0, 255));
            endcase
            applyStimulus(rv, rd, 1);
         end
      end
      rst = 1'b0;
      applyStimulus(1'b0, 8'h00, 3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
